muldiv_e: RTL and testbench
===========================

// Module: muldiv_e
// PURPOSE
//  Iterative multiply/divide unit in the Execute stage, downstream of the decode/execute pipeline register.
//  Consumes the E-stage operands (ReadData1E/ReadData2E after forwarding) and owns the architectural HI/LO registers.
//  Executes MULT/MULTU/DIV/DIVU over WIDTH+1 cycles and raises BusyE so the hazard unit stalls F/D/E.
//  Serves MFHI/MFLO reads and MTHI/MTLO writes.
// PARAMETERS
//  WIDTH  32  operand and HI/LO width; the iteration count equals WIDTH
// PORTS
//  clk       in   1      clock; all state updates on the rising edge
//  reset     in   1      asynchronous, active-high reset
//  StartE    in   1      op valid this cycle; sampled only in IDLE
//  MdOpE     in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MFHI, 111 MFLO
//  SrcAE     in   WIDTH  rs operand (dividend / multiplicand / MT source)
//  SrcBE     in   WIDTH  rt operand (divisor / multiplier)
//  FlushE    in   1      E-stage flush; aborts an in-flight op
//  BusyE     out  1      state != IDLE (combinational from state); stall request
//  DoneE     out  1      one-cycle pulse; first cycle in which the new HI/LO are visible
//  HiLoOutE  out  WIDTH  MdOpE==110 ? HI : LO (combinational); valid only when BusyE==0
// BEHAVIOUR
//  Reset: state=IDLE, HI=LO=0, BusyE=0, DoneE=0, iteration counter=0; all internal datapath regs cleared.
//  FSM: IDLE -> RUN -> FIX -> IDLE.
//  IDLE:
//   - StartE=1 with a MULT/DIV op (000-011) and FlushE=0 latches operands and op, then -> RUN.
//   - Signed ops latch magnitudes plus sign flags; unsigned ops latch raw values.
//   - MTHI/MTLO with StartE=1 writes SrcAE into HI/LO at that edge; state stays IDLE, no DoneE.
//   - MFHI/MFLO: no state change.
//  RUN: exactly WIDTH cycles, counter 0..WIDTH-1.
//   - Multiply: shift-add, one multiplier bit per cycle, into a 2*WIDTH product.
//   - Divide: restoring shift-subtract, one quotient bit per cycle.
//   - After the last iteration -> FIX.
//  FIX: one cycle.
//   - Signed multiply: the product is negated when signA^signB.
//   - Signed divide: quotient is negated when signA^signB; remainder is negated when signA.
//   - HI:LO is written at the end of FIX (mult: HI=product[2W-1:W], LO=product[W-1:0]; div: LO=quotient, HI=remainder).
//   - Then -> IDLE, and DoneE=1 for that next cycle.
//  Latency: accept at cycle 0; BusyE is high in cycles 1..WIDTH+1; new HI/LO and DoneE appear at cycle WIDTH+2.
//  Divide by zero (SrcBE==0, signed or unsigned):
//   - Same latency.
//   - Result is LO=all ones, HI=the original SrcAE bit pattern.
//  Signed overflow (-2^(W-1) / -1): LO=0x80000000, HI=0 for W=32. No trap.
//  StartE while BusyE=1: ignored. The hazard unit holds the instruction in E, so it is re-presented after completion.
//  FlushE=1 in RUN or FIX: next state IDLE, HI/LO unchanged, no DoneE.
//  FlushE=1 together with StartE in IDLE: the op is not accepted. This includes MTHI/MTLO (no write).
//  Reset asserted mid-operation: immediate return to the reset values above.
//  Multiply arithmetic is modulo 2^(2W); no width extension beyond 2W is kept.
// TESTING
//  1. MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> at cycle 34: HI=0xFFFFFFFE, LO=0x00000001, DoneE 1 cycle, BusyE high cycles 1..33.
//  2. MULT A=-3 (0xFFFFFFFD), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV A=-7, B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
//  3. DIVU A=100, B=0 -> LO=0xFFFFFFFF, HI=100; DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
//  4. MTHI 0x1234 then MFHI -> HiLoOutE=0x1234 the next cycle; BusyE never asserted.
//  5. DIVU 50/7 started, FlushE at cycle 10 -> IDLE at cycle 11, HI/LO keep prior values, no DoneE.
//  6. Reset pulsed at cycle 5 of a MULT -> BusyE=0, HI=LO=0 immediately; StartE during busy -> no effect on result.

Source files
------------

// File: rtl/muldiv_e.sv
// Iterative multiply/divide unit for the Execute stage; owns the HI/LO registers.
// One multiplier/quotient bit per cycle, followed by a single sign-fixup cycle.
module muldiv_e #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StartE,
    input  logic [2:0]       MdOpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             FlushE,
    output logic             BusyE,
    output logic             DoneE,
    output logic [WIDTH-1:0] HiLoOutE
);

    // state  | meaning
    // S_IDLE | waiting for an op; MT/MF served here
    // S_RUN  | WIDTH shift-add / shift-subtract iterations
    // S_FIX  | sign correction, HI/LO written at end of cycle
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t              r_state;
    state_t              w_next;
    logic [CW-1:0]       r_cnt;
    logic [2*WIDTH-1:0]  r_prod;
    logic [WIDTH-1:0]    r_mcd;
    logic [WIDTH-1:0]    r_araw;
    logic [WIDTH-1:0]    r_hi;
    logic [WIDTH-1:0]    r_lo;
    logic                r_isdiv;
    logic                r_sa;
    logic                r_sb;
    logic                r_divz;
    logic                r_done;

    logic                w_idle;
    logic                w_start_md;
    logic                w_mt;
    logic                w_last;
    logic                w_signed_op;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [WIDTH-1:0]    w_a_mag;
    logic [WIDTH-1:0]    w_b_mag;

    assign w_idle      = (r_state == S_IDLE);
    assign w_start_md  = w_idle && StartE && !FlushE && !MdOpE[2];
    assign w_mt        = w_idle && StartE && !FlushE && (MdOpE[2:1] == 2'b10);
    assign w_last      = (r_cnt == CW'(WIDTH - 1));

    // Even opcodes (MULT, DIV) are the signed forms.
    assign w_signed_op = !MdOpE[0];
    assign w_a_neg     = w_signed_op && SrcAE[WIDTH-1];
    assign w_b_neg     = w_signed_op && SrcBE[WIDTH-1];
    assign w_a_mag     = w_a_neg ? (-SrcAE) : SrcAE;
    assign w_b_mag     = w_b_neg ? (-SrcBE) : SrcBE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_md) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (FlushE) begin
                    w_next = S_IDLE;
                end else if (w_last) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Multiply step: product upper half accumulates, whole register shifts right.
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_step;

    assign w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                      + (r_prod[0] ? {1'b0, r_mcd} : {(WIDTH+1){1'b0}});
    assign w_mul_step = {w_mul_sum, r_prod[WIDTH-1:1]};

    // Divide step: upper half is the partial remainder, lower half shifts the
    // dividend out and the quotient bits in.
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH:0]       w_div_diff;
    logic                 w_div_ge;
    logic [WIDTH-1:0]     w_div_rem;
    logic [2*WIDTH-1:0]   w_div_step;

    assign w_div_shift = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_mcd});
    assign w_div_diff  = w_div_shift - {1'b0, r_mcd};
    assign w_div_rem   = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
    assign w_div_step  = {w_div_rem, r_prod[WIDTH-2:0], w_div_ge};

    logic [2*WIDTH-1:0]   w_mul_res;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_res_hi;
    logic [WIDTH-1:0]     w_res_lo;

    assign w_mul_res = (r_sa ^ r_sb) ? (-r_prod) : r_prod;
    assign w_quo     = (r_sa ^ r_sb) ? (-r_prod[WIDTH-1:0]) : r_prod[WIDTH-1:0];
    assign w_rem     = r_sa ? (-r_prod[2*WIDTH-1:WIDTH]) : r_prod[2*WIDTH-1:WIDTH];

    always_comb begin
        w_res_hi = w_mul_res[2*WIDTH-1:WIDTH];
        w_res_lo = w_mul_res[WIDTH-1:0];
        if (r_isdiv) begin
            if (r_divz) begin
                // Divide by zero bypasses sign fixup: HI returns the raw dividend.
                w_res_hi = r_araw;
                w_res_lo = {WIDTH{1'b1}};
            end else begin
                w_res_hi = w_rem;
                w_res_lo = w_quo;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_prod  <= '0;
            r_mcd   <= '0;
            r_araw  <= '0;
            r_isdiv <= 1'b0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_divz  <= 1'b0;
        end else if (w_start_md) begin
            r_cnt   <= '0;
            r_isdiv <= MdOpE[1];
            r_sa    <= w_a_neg;
            r_sb    <= w_b_neg;
            r_araw  <= SrcAE;
            r_divz  <= MdOpE[1] && (SrcBE == '0);
            r_mcd   <= MdOpE[1] ? w_b_mag : w_a_mag;
            r_prod  <= {{WIDTH{1'b0}}, (MdOpE[1] ? w_a_mag : w_b_mag)};
        end else if (r_state == S_RUN) begin
            r_cnt   <= r_cnt + 1'b1;
            r_prod  <= r_isdiv ? w_div_step : w_mul_step;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIX) && !FlushE;
            if (w_mt) begin
                if (MdOpE[0]) begin
                    r_lo <= SrcAE;
                end else begin
                    r_hi <= SrcAE;
                end
            end else if ((r_state == S_FIX) && !FlushE) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end
    end

    assign BusyE    = !w_idle;
    assign DoneE    = r_done;
    assign HiLoOutE = (MdOpE == 3'b110) ? r_hi : r_lo;

endmodule

// File: tb/tb_muldiv_e.sv
// Directed bench for muldiv_e: hand-computed HI/LO results, latency,
// flush, reset and MT/MF behaviour.
module tb_muldiv_e;

    logic        clk;
    logic        reset;
    logic        StartE;
    logic [2:0]  MdOpE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        FlushE;
    logic        BusyE;
    logic        DoneE;
    logic [31:0] HiLoOutE;

    int n_vec;
    int n_err;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MFHI  = 3'b110;
    localparam logic [2:0] OP_MFLO  = 3'b111;

    muldiv_e #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .StartE   (StartE),
        .MdOpE    (MdOpE),
        .SrcAE    (SrcAE),
        .SrcBE    (SrcBE),
        .FlushE   (FlushE),
        .BusyE    (BusyE),
        .DoneE    (DoneE),
        .HiLoOutE (HiLoOutE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        MdOpE = OP_MFHI;
        #1;
        check({tag, ".hi"}, HiLoOutE, hi);
        MdOpE = OP_MFLO;
        #1;
        check({tag, ".lo"}, HiLoOutE, lo);
    endtask

    // Full op: expects BusyE for exactly 33 cycles, DoneE at cycle 34, one-cycle pulse.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                          input bit junk);
        int n;
        MdOpE  = op;
        SrcAE  = a;
        SrcBE  = b;
        StartE = 1'b1;
        tick();
        StartE = 1'b0;
        n = 0;
        while (BusyE && n < 100) begin
            n++;
            if (junk && n <= 31) begin
                StartE = 1'b1;
                MdOpE  = OP_DIV;
                SrcAE  = $urandom;
                SrcBE  = $urandom;
            end else begin
                StartE = 1'b0;
            end
            tick();
        end
        StartE = 1'b0;
        check({tag, ".busy_cycles"}, 32'(n), 32'd33);
        check({tag, ".done"}, {31'd0, DoneE}, 32'd1);
        check_hilo(tag, hi, lo);
        tick();
        check({tag, ".done_pulse"}, {31'd0, DoneE}, 32'd0);
    endtask

    // Start an op and flush it while in cycle cyc; HI/LO must keep hi/lo.
    task automatic flush_at(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input int cyc,
                            input logic [31:0] hi, input logic [31:0] lo);
        MdOpE  = op;
        SrcAE  = a;
        SrcBE  = b;
        StartE = 1'b1;
        tick();
        StartE = 1'b0;
        for (int c = 1; c < cyc; c++) tick();
        check({tag, ".busy_before"}, {31'd0, BusyE}, 32'd1);
        FlushE = 1'b1;
        tick();
        FlushE = 1'b0;
        check({tag, ".busy_after"}, {31'd0, BusyE}, 32'd0);
        check({tag, ".done"}, {31'd0, DoneE}, 32'd0);
        tick();
        check({tag, ".done_late"}, {31'd0, DoneE}, 32'd0);
        check_hilo(tag, hi, lo);
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        reset  = 1'b1;
        StartE = 1'b0;
        MdOpE  = OP_MFHI;
        SrcAE  = '0;
        SrcBE  = '0;
        FlushE = 1'b0;
        tick();
        tick();
        check("rst.busy", {31'd0, BusyE}, 32'd0);
        check("rst.done", {31'd0, DoneE}, 32'd0);
        check_hilo("rst", 32'h0, 32'h0);
        reset = 1'b0;
        tick();

        run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op("mult_m3x7", OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        run_op("mult_m3xm5", OP_MULT, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F, 1'b0);
        run_op("div_m7d2",  OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("div_7dm2",  OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
        run_op("divu_50d7", OP_DIVU,  32'd50,       32'd7,        32'h00000001, 32'h00000007, 1'b0);
        run_op("divu_z",    OP_DIVU,  32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b0);
        run_op("div_z_neg", OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0);
        run_op("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);

        // MTHI / MTLO followed by MF reads; no busy, no done
        MdOpE = OP_MTHI; SrcAE = 32'h00001234; StartE = 1'b1;
        tick();
        StartE = 1'b0;
        MdOpE  = OP_MFHI;
        #1;
        check("mthi.read", HiLoOutE, 32'h00001234);
        check("mthi.busy", {31'd0, BusyE}, 32'd0);
        check("mthi.done", {31'd0, DoneE}, 32'd0);
        MdOpE = OP_MTLO; SrcAE = 32'h00005678; StartE = 1'b1;
        tick();
        StartE = 1'b0;
        check("mtlo.busy", {31'd0, BusyE}, 32'd0);
        check_hilo("mtlo", 32'h00001234, 32'h00005678);

        // Flush alongside StartE in IDLE blocks both MT writes and op acceptance
        MdOpE = OP_MTHI; SrcAE = 32'hDEADBEEF; StartE = 1'b1; FlushE = 1'b1;
        tick();
        MdOpE = OP_MULTU; SrcAE = 32'd3; SrcBE = 32'd4;
        tick();
        StartE = 1'b0; FlushE = 1'b0;
        check("flush_idle.busy", {31'd0, BusyE}, 32'd0);
        check_hilo("flush_idle", 32'h00001234, 32'h00005678);

        flush_at("flush_run", OP_DIVU, 32'd50, 32'd7, 10, 32'h00001234, 32'h00005678);
        flush_at("flush_fix", OP_MULTU, 32'd9, 32'd9, 33, 32'h00001234, 32'h00005678);

        // Asynchronous reset in the middle of a MULT
        MdOpE = OP_MULT; SrcAE = 32'd3; SrcBE = 32'd5; StartE = 1'b1;
        tick();
        StartE = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        check("rst_mid.busy_before", {31'd0, BusyE}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mid.busy", {31'd0, BusyE}, 32'd0);
        check("rst_mid.done", {31'd0, DoneE}, 32'd0);
        check_hilo("rst_mid", 32'h0, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        check("rst_mid.idle", {31'd0, BusyE}, 32'd0);

        // StartE held with other operands while busy must not disturb the result
        run_op("busy_start", OP_MULTU, 32'd6, 32'd7, 32'h00000000, 32'h0000002A, 1'b1);
        run_op("after_busy", OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout vectors=%0d", n_vec);
        $fatal(1, "timeout");
    end

endmodule
